// File: rtl/uart_byte_tx.sv
// uart_byte_tx
//   UART transmit stage. Bytes arrive over a valid/ready handshake and are
//   queued in a small FIFO. They are then sent LSB first onto the serial
//   line as 8N1 frames, or as 8E1 frames when parity is enabled.
//   If bytes are still queued when a stop bit ends, the next start bit
//   follows directly, with no idle gap between frames.
//
// Optional feature macro: UART_TX_PARITY_EN
//   When defined, an even-parity bit is sent after data bit 7 (8E1 frame).
//
// Ports
//   clock          system clock, rising edge
//   reset_n        synchronous active-low reset
//   tx_data        byte to enqueue
//   tx_valid       tx_data is valid
//   tx_ready       FIFO can accept a byte (transfer when tx_valid && tx_ready)
//   uart_tx        registered serial output, idle high
//   tx_busy        high while any frame bit is being driven
//   fifo_count     bytes queued but not yet started
//   fifo_overflow  sticky; set when tx_valid is seen while tx_ready is low

module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int FIFO_AW      = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [7:0]         tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic               uart_tx,
    output logic               tx_busy,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               fifo_overflow
);

    localparam int                 DEPTH     = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0]   DEPTH_CNT = DEPTH[FIFO_AW:0];
    localparam logic [31:0]        LAST_TICK = 32'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_PARITY = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
    } state_t;
`endif

    logic [7:0]          r_mem [0:DEPTH-1];
    logic [FIFO_AW-1:0]  r_wrPtr;
    logic [FIFO_AW-1:0]  r_rdPtr;
    logic [FIFO_AW:0]    r_count;
    logic                r_overflow;

    state_t              r_state;
    logic [31:0]         r_timer;
    logic [2:0]          r_bitIdx;
    logic [7:0]          r_shift;
    logic                r_tx;

    state_t              w_stateNext;
    logic [31:0]         w_timerNext;
    logic [2:0]          w_bitIdxNext;
    logic                w_pop;
    logic                w_push;
    logic                w_txNext;
    logic                w_bitDone;

    assign tx_ready      = (r_count < DEPTH_CNT) && reset_n;
    assign w_push        = tx_valid && tx_ready;
    assign w_bitDone     = (r_timer == LAST_TICK);
    assign uart_tx       = r_tx;
    assign tx_busy       = (r_state != S_IDLE);
    assign fifo_count    = r_count;
    assign fifo_overflow = r_overflow;

    // FIFO storage has no reset; resetting the pointers discards its contents.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= tx_data;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    // The FSM only pops when the count is non-zero, so the count cannot underflow.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (tx_valid && !tx_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // FSM state register. The head byte is copied into the shift register
    // at pop time, so later FIFO writes cannot disturb a frame in flight.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_timer  <= '0;
            r_bitIdx <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
        end else begin
            r_state  <= w_stateNext;
            r_timer  <= w_timerNext;
            r_bitIdx <= w_bitIdxNext;
            r_tx     <= w_txNext;
            if (w_pop) begin
                r_shift <= r_mem[r_rdPtr];
            end
        end
    end

    // Next-state logic. The line level is derived from the next state, so
    // uart_tx leaves a flop and changes on the same edge as the state.
    always_comb begin
        w_stateNext  = r_state;
        w_timerNext  = r_timer + 32'd1;
        w_bitIdxNext = r_bitIdx;
        w_pop        = 1'b0;
        w_txNext     = 1'b1;

        case (r_state)
            S_IDLE: begin
                w_timerNext = '0;
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_stateNext = S_START;
                end
            end
            S_START: begin
                if (w_bitDone) begin
                    w_stateNext  = S_DATA;
                    w_timerNext  = '0;
                    w_bitIdxNext = '0;
                end
            end
            S_DATA: begin
                if (w_bitDone) begin
                    w_timerNext = '0;
                    if (r_bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_stateNext = S_PARITY;
`else
                        w_stateNext = S_STOP;
`endif
                    end else begin
                        w_bitIdxNext = r_bitIdx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bitDone) begin
                    w_stateNext = S_STOP;
                    w_timerNext = '0;
                end
            end
`endif
            S_STOP: begin
                if (w_bitDone) begin
                    w_timerNext = '0;
                    if (r_count != '0) begin
                        w_pop       = 1'b1;
                        w_stateNext = S_START;
                    end else begin
                        w_stateNext = S_IDLE;
                    end
                end
            end
            default: begin
                w_stateNext = S_IDLE;
                w_timerNext = '0;
            end
        endcase

        case (w_stateNext)
            S_START:  w_txNext = 1'b0;
            S_DATA:   w_txNext = r_shift[w_bitIdxNext];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_txNext = ^r_shift;
`endif
            default:  w_txNext = 1'b1;
        endcase
    end

endmodule
